// File: rtl/datapath_ctrl.sv
// Hardwired T0..T6 control sequencer for the single-bus datapath.
// Moore outputs decode only the state register and the opcode latched at the end of T2.
module datapath_ctrl #(
    parameter int OP_W  = 5,
    parameter int ALU_W = 5
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Stop,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [ALU_W-1:0] ALUop,
    output logic             Run,
    output logic             Illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b01001);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b01010);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    logic [3:0]       state, state_next;
    logic [OP_W-1:0]  op_q;
    logic             is_alu, is_md, is_nop, is_halt;
    logic [ALU_W-1:0] alu_sel;
    logic [3:0]       boundary;
    logic             unused_ir;

    // Only the opcode field is consumed here; register fields go to the select encoder.
    assign unused_ir = ^IR[31-OP_W:0];

    always_comb begin
        is_alu  = 1'b0;
        is_md   = 1'b0;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        alu_sel = '0;
        case (op_q)
            OP_ADD:  begin is_alu = 1'b1; alu_sel = ALU_W'(1); end
            OP_SUB:  begin is_alu = 1'b1; alu_sel = ALU_W'(2); end
            OP_AND:  begin is_alu = 1'b1; alu_sel = ALU_W'(3); end
            OP_OR:   begin is_alu = 1'b1; alu_sel = ALU_W'(4); end
            OP_MUL:  begin is_md  = 1'b1; alu_sel = ALU_W'(5); end
            OP_DIV:  begin is_md  = 1'b1; alu_sel = ALU_W'(6); end
            OP_NOP:  is_nop  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Every instruction boundary funnels through here so Stop is honoured uniformly.
    always_comb begin
        boundary   = Stop ? S_IDLE : S_T0;
        state_next = state;
        case (state)
            S_IDLE: state_next = boundary;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (is_halt)              state_next = S_HALT;
                else if (is_alu || is_md) state_next = S_T4;
                else                      state_next = boundary;
            end
            S_T4:   state_next = S_T5;
            S_T5:   state_next = is_md ? S_T6 : boundary;
            S_T6:   state_next = boundary;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == S_T2)
                op_q <= IR[31 -: OP_W];
        end
    end

    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        ALUop    = '0;
        Illegal  = 1'b0;
        Run      = (state >= S_T0) && (state <= S_T6);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Grc   = is_alu;
                Grb   = is_md;
                Rout  = 1'b1;
                Zin   = 1'b1;
                ALUop = alu_sel;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = is_alu;
                Rin     = is_alu;
                LOin    = is_md;
            end
            S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: directed scenarios plus randomized IR/Stop
// traffic, all checked every cycle against an instruction-level reference model.
module tb_datapath_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic        Stop = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
    logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Illegal;
    logic [4:0] ALUop;

    datapath_ctrl #(.OP_W(5), .ALU_W(5)) dut (
        .Clock(Clock), .Resetn(Resetn), .Stop(Stop), .IR(IR),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .ALUop(ALUop), .Run(Run), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pc_out, zh_out, zl_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
        logic y_in, z_in, hi_in, lo_in, inc_pc, rd, gra, grb, grc, r_in, r_out;
        logic illegal, run;
        logic [4:0] alu;
    } outs_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    localparam logic [31:0] IR_AND  = 32'h4A920000;
    localparam logic [31:0] IR_MUL  = 32'h79100000;
    localparam logic [31:0] IR_DIV  = 32'h81A00000;
    localparam logic [31:0] IR_ADD  = 32'h18C40000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;

    int total = 0;
    int bad   = 0;
    int m_mode = M_IDLE;
    int m_step = 0;
    logic [4:0] m_op = '0;

    // Instruction classes: 0 illegal, 1 three-operand ALU, 2 mul/div, 3 nop, 4 halt.
    function automatic int cls_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010: return 1;
            5'b01111, 5'b10000:                     return 2;
            5'b11010:                               return 3;
            5'b11011:                               return 4;
            default:                                return 0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011: return 5'd1;
            5'b00100: return 5'd2;
            5'b01001: return 5'd3;
            5'b01010: return 5'd4;
            5'b01111: return 5'd5;
            5'b10000: return 5'd6;
            default:  return 5'd0;
        endcase
    endfunction

    function automatic int len_of(input int cls);
        return (cls == 1) ? 6 : (cls == 2) ? 7 : 4;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        case ($urandom_range(0, 7))
            0: op = 5'b00011;
            1: op = 5'b00100;
            2: op = 5'b01001;
            3: op = 5'b01010;
            4: op = 5'b01111;
            5: op = 5'b10000;
            6: op = 5'b11010;
            default: begin
                op = 5'($urandom_range(0, 31));
                if (cls_of(op) != 0) op = 5'b11111;
            end
        endcase
        return {op, 27'($urandom)};
    endfunction

    function outs_t dut_outs();
        return {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                Illegal, Run, ALUop};
    endfunction

    function outs_t expect_outs();
        outs_t e;
        int c;
        e = '0;
        c = cls_of(m_op);
        if (m_mode == M_RUN) begin
            e.run = 1'b1;
            case (m_step)
                0: begin e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; end
                1: begin e.zl_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1; end
                2: begin e.mdr_out = 1; e.ir_in = 1; end
                3: begin
                    if (c == 1)      begin e.grb = 1; e.r_out = 1; e.y_in = 1; end
                    else if (c == 2) begin e.gra = 1; e.r_out = 1; e.y_in = 1; end
                    else if (c == 0) e.illegal = 1;
                end
                4: begin
                    e.r_out = 1; e.z_in = 1; e.alu = alu_of(m_op);
                    if (c == 1) e.grc = 1; else e.grb = 1;
                end
                5: begin
                    e.zl_out = 1;
                    if (c == 1) begin e.gra = 1; e.r_in = 1; end
                    else e.lo_in = 1;
                end
                6: begin e.zh_out = 1; e.hi_in = 1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic model_edge();
        if (!Resetn) return;
        case (m_mode)
            M_IDLE: if (!Stop) begin m_mode = M_RUN; m_step = 0; end
            M_RUN: begin
                if (m_step == 2) m_op = IR[31:27];
                if (m_step == 3 && cls_of(m_op) == 4) m_mode = M_HALT;
                else if (m_step + 1 == len_of(cls_of(m_op))) begin
                    m_step = 0;
                    if (Stop) m_mode = M_IDLE;
                end else m_step++;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string tag);
        outs_t got, exp;
        int drivers;
        got = dut_outs();
        exp = expect_outs();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
        drivers = $countones({got.pc_out, got.zh_out, got.zl_out, got.mdr_out, got.r_out});
        total++;
        assert (drivers <= 1) else begin
            bad++;
            $error("[TB] FAIL %s_bus: observed drivers=%0d expected<=1", tag, drivers);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic stop_v, input logic [31:0] ir_v, input string tag);
        Stop = stop_v;
        IR   = ir_v;
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        checkOutput(tag);
    endtask

    task automatic assert_reset(input string tag);
        Resetn = 1'b0;
        m_mode = M_IDLE;
        m_step = 0;
        m_op   = '0;
        #1;
        checkOutput(tag);
    endtask

    task automatic release_reset();
        @(posedge Clock);
        #1 Resetn = 1'b1;
        @(negedge Clock);
        checkOutput("post_reset_idle");
    endtask

    task automatic measure_gap(input logic [31:0] ir_v, output int n);
        n = 0;
        do begin
            applyStimulus(1'b0, ir_v, "gap");
            n++;
        end while (PCout !== 1'b1 && n < 12);
    endtask

    initial begin
        int n;
        #2 assert_reset("reset");
        check_bit("reset_run", Run, 1'b0);
        release_reset();
        check_bit("idle_pcout", PCout, 1'b0);

        applyStimulus(1'b0, IR_AND, "first_t0");
        check_bit("first_t0_pcout", PCout, 1'b1);
        check_bit("first_t0_incpc", IncPC, 1'b1);
        measure_gap(IR_AND, n);
        check_int("and_len", n, 6);
        measure_gap(IR_MUL, n);
        check_int("mul_len", n, 7);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, IR_DIV, "div_fetch");
        applyStimulus(1'b0, IR_DIV, "div_t4");
        check_int("div_aluop", int'(ALUop), 6);
        applyStimulus(1'b1, IR_DIV, "div_t5");
        check_bit("div_t5_lo", LOin, 1'b1);
        applyStimulus(1'b1, IR_DIV, "div_t6");
        check_bit("div_t6_hi", HIin, 1'b1);
        applyStimulus(1'b1, IR_DIV, "stop_idle");
        check_bit("stop_idle_run", Run, 1'b0);
        applyStimulus(1'b0, IR_ILL, "resume_t0");
        check_bit("resume_pcout", PCout, 1'b1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, IR_ILL, "ill");
        check_bit("ill_pulse", Illegal, 1'b1);
        check_bit("ill_no_rin", Rin, 1'b0);
        applyStimulus(1'b0, IR_ILL, "ill_next_t0");
        check_bit("ill_back_t0", PCout, 1'b1);
        check_bit("ill_one_cycle", Illegal, 1'b0);

        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 7) == 0, rand_ir(), "random");

        assert_reset("reset2");
        release_reset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, IR_ADD, "add");
        check_int("add_t4_aluop", int'(ALUop), 1);
        #2 assert_reset("reset_mid_t4");
        check_bit("reset_mid_rin", Rin, 1'b0);
        release_reset();
        check_bit("reset_mid_no_wb", Zlowout, 1'b0);
        applyStimulus(1'b0, IR_HALT, "restart_t0");
        check_bit("restart_pcout", PCout, 1'b1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, IR_HALT, "halt_fetch");
        applyStimulus(1'b0, IR_NOP, "halt_enter");
        check_bit("halt_run", Run, 1'b0);
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, rand_ir(), "halt_hold");
        check_bit("halt_held_pcout", PCout, 1'b0);
        assert_reset("reset3");
        release_reset();
        applyStimulus(1'b0, IR_NOP, "after_halt_t0");
        check_bit("after_halt_pcout", PCout, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
